// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encodings,
// depth limit and the per-bit evaluation function.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_ANDN = 2'd3
    } lu_op_e;

    localparam int STAGES_MAX = 4;

    // Operates on one bit so the same function serves any operand width.
    function automatic logic lu_eval(input lu_op_e op, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ANDN: r = a & ~b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_slice.sv
// One pipeline register stage carrying {valid, result, zf, sf}, with a shared
// advance enable and asynchronous clear.
module logic_unit_slice #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_zf,
    input  logic             i_sf,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zf,
    output logic             o_sf
);

    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_zf;
    logic             r_sf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_zf    <= 1'b0;
            r_sf    <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_res   <= i_res;
            r_zf    <= i_zf;
            r_sf    <= i_sf;
        end
    end

    assign o_valid = r_valid;
    assign o_res   = r_res;
    assign o_zf    = r_zf;
    assign o_sf    = r_sf;

endmodule

// File: rtl/logic_unit_pipe.sv
// Valid/ready pipelined AND/OR/XOR/ANDN unit with ZF/SF flags; the whole pipe
// advances together and freezes when the output is held.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zf,
    output logic             out_sf,
    output logic             busy
);

    logic             w_adv;
    logic             r_opValid;
    lu_op_e           r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_evalRes;

    logic [STAGES:0]  w_valid;
    logic [WIDTH-1:0] w_res [STAGES+1];
    logic [STAGES:0]  w_zf;
    logic [STAGES:0]  w_sf;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Operand capture register; stage 1 evaluates from these registered operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opValid <= 1'b0;
            r_op      <= OP_AND;
            r_a       <= '0;
            r_b       <= '0;
        end else if (w_adv) begin
            r_opValid <= in_valid;
            r_op      <= lu_op_e'(in_op);
            r_a       <= in_a;
            r_b       <= in_b;
        end
    end

    always_comb begin
        w_evalRes = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_evalRes[i] = lu_eval(r_op, r_a[i], r_b[i]);
        end
    end

    // Flags are formed once here and only carried by later stages.
    assign w_valid[0] = r_opValid;
    assign w_res[0]   = w_evalRes;
    assign w_zf[0]    = ~|w_evalRes;
    assign w_sf[0]    = w_evalRes[WIDTH-1];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic_unit_slice #(.WIDTH(WIDTH)) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_valid(w_valid[g]),
            .i_res  (w_res[g]),
            .i_zf   (w_zf[g]),
            .i_sf   (w_sf[g]),
            .o_valid(w_valid[g+1]),
            .o_res  (w_res[g+1]),
            .o_zf   (w_zf[g+1]),
            .o_sf   (w_sf[g+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign out_res   = w_res[STAGES];
    assign out_zf    = w_zf[STAGES];
    assign out_sf    = w_sf[STAGES];
    assign busy      = |w_valid;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks of logic_unit_pipe: latency, ops/flags,
// backpressure, mid-stream reset and a scoreboarded sweep over widths/depths.
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;

    logic        inValid, inReady, outValid, outReady, outZf, outSf, busy;
    logic [1:0]  inOp;
    logic [63:0] inA, inB, outRes;

    logic        s1InValid, s1InReady, s1OutValid, s1OutReady, s1OutZf, s1OutSf, s1Busy;
    logic [1:0]  s1InOp;
    logic [31:0] s1InA, s1InB, s1OutRes;

    logic        s4InValid, s4InReady, s4OutValid, s4OutReady, s4OutZf, s4OutSf, s4Busy;
    logic [1:0]  s4InOp;
    logic [63:0] s4InA, s4InB, s4OutRes;

    logic_unit_pipe #(.WIDTH(64), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady), .in_op(inOp),
        .in_a(inA), .in_b(inB), .out_valid(outValid), .out_ready(outReady),
        .out_res(outRes), .out_zf(outZf), .out_sf(outSf), .busy(busy));

    logic_unit_pipe #(.WIDTH(32), .STAGES(1)) dutS1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1InValid), .in_ready(s1InReady), .in_op(s1InOp),
        .in_a(s1InA), .in_b(s1InB), .out_valid(s1OutValid), .out_ready(s1OutReady),
        .out_res(s1OutRes), .out_zf(s1OutZf), .out_sf(s1OutSf), .busy(s1Busy));

    logic_unit_pipe #(.WIDTH(64), .STAGES(4)) dutS4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s4InValid), .in_ready(s4InReady), .in_op(s4InOp),
        .in_a(s4InA), .in_b(s4InB), .out_valid(s4OutValid), .out_ready(s4OutReady),
        .out_res(s4OutRes), .out_zf(s4OutZf), .out_sf(s4OutSf), .busy(s4Busy));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] refEval(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] expRes,
                                 input logic expZf, input logic expSf);
        int lat;
        outReady = 1'b1;
        inValid  = 1'b1;
        inOp     = op;
        inA      = a;
        inB      = b;
        #1;
        checkOutput({tag, "_inready"}, 64'(inReady), 64'd1);
        tick();
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 10) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd2);
        checkOutput({tag, "_res"}, outRes, expRes);
        checkOutput({tag, "_zf"}, 64'(outZf), 64'(expZf));
        checkOutput({tag, "_sf"}, 64'(outSf), 64'(expSf));
        tick();
    endtask

    initial begin
        logic [63:0] held, expV;
        logic        stalled;
        int          sent, got, staleSeen;
        int          in1, out1, in4, out4;
        logic [63:0] q1[$];
        logic [63:0] q4[$];

        checks = 0; failures = 0;
        rst_n = 1'b0;
        inValid = 1'b1; inOp = 2'd1; inA = '1; inB = '1; outReady = 1'b1;
        s1InValid = 1'b0; s1InOp = '0; s1InA = '0; s1InB = '0; s1OutReady = 1'b0;
        s4InValid = 1'b0; s4InOp = '0; s4InA = '0; s4InB = '0; s4OutReady = 1'b0;

        // Reset held with input valid asserted.
        repeat (3) tick();
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_out_res", outRes, 64'd0);
        checkOutput("rst_out_zf", 64'(outZf), 64'd0);
        checkOutput("rst_out_sf", 64'(outSf), 64'd0);
        rst_n = 1'b1;
        inValid = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(inReady), 64'd1);
        tick();

        $display("[TB] latency and op/flag vectors");
        applyStimulus("and_lat", 2'd0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FF9B,
                      64'h0000_0000_FFFF_FF9B, 1'b0, 1'b0);
        applyStimulus("xor_zero", 2'd2, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234,
                      64'h0, 1'b1, 1'b0);
        applyStimulus("andn_sign", 2'd3, 64'h8000_0000_0000_0000, 64'h0,
                      64'h8000_0000_0000_0000, 1'b0, 1'b1);
        applyStimulus("or_byte", 2'd1, 64'h0F, 64'hF0, 64'hFF, 1'b0, 1'b0);
        applyStimulus("and_lo", 2'd0, 64'hF0F0_F0F0_1234_5678, 64'h0F0F_FFFF_0000_FFFF,
                      64'h0000_F0F0_0000_5678, 1'b0, 1'b0);

        $display("[TB] backpressure stream");
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 80 && got < 16; c++) begin
            outReady = !(c >= 3 && c <= 7);
            inValid  = (sent < 16);
            inOp     = 2'd0;
            inA      = 64'h0000_0000_FFFF_FFFF - 64'(sent);
            inB      = 64'h0000_0000_FFFF_FFFF;
            #1;
            if (stalled) begin
                checkOutput("bp_hold_valid", 64'(outValid), 64'd1);
                checkOutput("bp_hold_res", outRes, held);
            end
            stalled = outValid && !outReady;
            if (stalled) begin
                checkOutput("bp_in_ready", 64'(inReady), 64'd0);
                held = outRes;
            end
            if (inValid && inReady) sent++;
            if (outValid && outReady) begin
                checkOutput("bp_order", outRes, 64'h0000_0000_FFFF_FFFF - 64'(got));
                got++;
            end
            tick();
        end
        inValid = 1'b0;
        checkOutput("bp_count", 64'(got), 64'd16);
        repeat (3) tick();

        $display("[TB] reset with entries in flight");
        outReady = 1'b1;
        inOp = 2'd1; inA = 64'h1111; inB = 64'h2222;
        inValid = 1'b1;
        tick();
        inA = 64'h3333;
        tick();
        inValid = 1'b0;
        checkOutput("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy_rst", 64'(busy), 64'd0);
        checkOutput("mid_valid_rst", 64'(outValid), 64'd0);
        tick();
        rst_n = 1'b1;
        staleSeen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (outValid) staleSeen++;
        end
        checkOutput("mid_stale", 64'(staleSeen), 64'd0);
        applyStimulus("mid_next", 2'd2, 64'hFF00, 64'h0FF0, 64'hF0F0, 1'b0, 1'b0);

        $display("[TB] random sweep");
        in1 = 0; out1 = 0; in4 = 0; out4 = 0;
        for (int c = 0; c < 700; c++) begin
            s1InValid  = (c < 600) && ($urandom_range(0, 1) == 1);
            s1InOp     = 2'($urandom_range(0, 3));
            s1InA      = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            s1InB      = 32'($urandom);
            s1OutReady = (c >= 600) || ($urandom_range(0, 3) != 0);
            s4InValid  = (c < 600) && ($urandom_range(0, 1) == 1);
            s4InOp     = 2'($urandom_range(0, 3));
            s4InA      = ($urandom_range(0, 7) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
            s4InB      = {32'($urandom), 32'($urandom)};
            s4OutReady = (c >= 600) || ($urandom_range(0, 3) != 0);
            #1;
            if (s1InValid && s1InReady) begin
                q1.push_back(refEval(s1InOp, {32'h0, s1InA}, {32'h0, s1InB}));
                in1++;
            end
            if (s1OutValid && s1OutReady) begin
                if (q1.size() == 0) begin
                    checkOutput("s1_unexpected", 64'd1, 64'd0);
                end else begin
                    expV = q1.pop_front();
                    checkOutput("s1_res", {32'h0, s1OutRes}, {32'h0, expV[31:0]});
                    checkOutput("s1_zf", 64'(s1OutZf), 64'(expV[31:0] == 32'h0));
                    checkOutput("s1_sf", 64'(s1OutSf), 64'(expV[31]));
                end
                out1++;
            end
            if (s4InValid && s4InReady) begin
                q4.push_back(refEval(s4InOp, s4InA, s4InB));
                in4++;
            end
            if (s4OutValid && s4OutReady) begin
                if (q4.size() == 0) begin
                    checkOutput("s4_unexpected", 64'd1, 64'd0);
                end else begin
                    expV = q4.pop_front();
                    checkOutput("s4_res", s4OutRes, expV);
                    checkOutput("s4_zf", 64'(s4OutZf), 64'(expV == 64'h0));
                    checkOutput("s4_sf", 64'(s4OutSf), 64'(expV[63]));
                end
                out4++;
            end
            tick();
        end
        checkOutput("s1_count", 64'(out1), 64'(in1));
        checkOutput("s4_count", 64'(out4), 64'(in4));
        checkOutput("s1_drained", 64'(q1.size()), 64'd0);
        checkOutput("s4_drained", 64'(q4.size()), 64'd0);
        checkOutput("s4_idle", 64'(s4Busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
